// File: rtl/var_delay_line_pkg.sv
// var_delay_line_pkg
//   Shared types and helpers for the variable-depth delay line.
//   - dl_state_t : control FSM states (FILL while the line is priming, RUN once primed)
//   - clamp_ok   : legality check for a requested delay depth (1..max)
package var_delay_line_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } dl_state_t;

    // A depth is legal when it addresses an existing stage: 1..max inclusive.
    function automatic logic clamp_ok(input int unsigned depth, input int unsigned max);
        return (depth >= 1) && (depth <= max);
    endfunction

endpackage

// File: rtl/var_delay_line_if.sv
// var_delay_line_if
//   Bundles the control, sample and result signals of var_delay_line.
//   master : the sample source / consumer (drives ce, flush, depth_load, depth_i, d_valid, d)
//   slave  : the delay line itself (drives q, q_valid, taps, primed, depth_err, dbg_state)
//
//   Handshake: a sample is taken on a rising clk edge when ce & d_valid & ~flush;
//   there is no backpressure. q_valid is a one-cycle registered pulse following the
//   accepting edge, and q holds its value until the next accepted sample.
interface var_delay_line_if
    import var_delay_line_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 1,
    parameter int MAX_DEPTH = 8
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    logic                              ce;
    logic                              flush;
    logic                              depth_load;
    logic [DW-1:0]                     depth_i;
    logic                              d_valid;
    logic [CHANNELS*WIDTH-1:0]         d;
    logic [CHANNELS*WIDTH-1:0]         q;
    logic                              q_valid;
    logic [MAX_DEPTH*CHANNELS*WIDTH-1:0] taps;
    logic                              primed;
    logic                              depth_err;
    dl_state_t                         dbg_state;

    modport master (
        output ce, flush, depth_load, depth_i, d_valid, d,
        input  q, q_valid, taps, primed, depth_err, dbg_state
    );

    modport slave (
        input  ce, flush, depth_load, depth_i, d_valid, d,
        output q, q_valid, taps, primed, depth_err, dbg_state
    );

endinterface

// File: rtl/var_delay_line_ctrl.sv
// var_delay_line_ctrl
//   Control path of the delay line: FILL/RUN FSM, fill counter, depth register,
//   sticky depth error and the registered q_valid pulse.
//   Inputs : clk, reset_n, ce, flush, depth_load, depth_i, d_valid
//   Outputs: accept (shift strobe), clr (data clear strobe), depth_r, q_valid,
//            primed, depth_err, state (debug view of the FSM)
module var_delay_line_ctrl
    import var_delay_line_pkg::*;
#(
    parameter int MAX_DEPTH = 8,
    localparam int DW = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          flush,
    input  logic          depth_load,
    input  logic [DW-1:0] depth_i,
    input  logic          d_valid,
    output logic          accept,
    output logic          clr,
    output logic [DW-1:0] depth_r,
    output logic          q_valid,
    output logic          primed,
    output logic          depth_err,
    output dl_state_t     state
);

    dl_state_t     state_nxt;
    logic [DW-1:0] fill_cnt, fill_nxt, depth_nxt;
    logic          legal, load_ok, load_bad, err_nxt, qv_nxt;

    always_comb begin
        clr      = ce & flush;
        accept   = ce & d_valid & ~flush;
        legal    = clamp_ok(32'(depth_i), MAX_DEPTH);
        load_ok  = ce & depth_load & legal;
        // flush outranks the error flag: a flush clears it even alongside a bad load
        load_bad = ce & depth_load & ~legal & ~flush;

        depth_nxt = load_ok ? depth_i : depth_r;

        fill_nxt = fill_cnt;
        if (clr)
            fill_nxt = '0;
        else if (load_ok)
            fill_nxt = accept ? DW'(1) : '0;
        else if (accept && (fill_cnt < depth_r))
            fill_nxt = fill_cnt + DW'(1);

        err_nxt = clr ? 1'b0 : (depth_err | load_bad);

        state_nxt = state;
        case (state)
            FILL: if (accept && (fill_nxt == depth_nxt)) state_nxt = RUN;
            RUN:  if (clr || load_ok)
                      // a new depth of 1 loaded with a sample is primed at once
                      state_nxt = (accept && (fill_nxt == depth_nxt)) ? RUN : FILL;
            default: state_nxt = FILL;
        endcase

        qv_nxt = accept && (fill_nxt >= depth_nxt);
    end

    // With ce low every *_nxt equals the current value and qv_nxt is 0, so the
    // registers need no explicit enable; q_valid thus drops while ce is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            depth_r   <= DW'(MAX_DEPTH);
            depth_err <= 1'b0;
            q_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            depth_r   <= depth_nxt;
            depth_err <= err_nxt;
            q_valid   <= qv_nxt;
        end
    end

    assign primed = (state == RUN);

endmodule

// File: rtl/var_delay_line.sv
// var_delay_line
//   Multi-channel runtime-programmable delay line. CHANNELS samples of WIDTH bits
//   shift in lockstep through MAX_DEPTH stages on every accepted sample; q reads
//   stage depth_r-1 combinationally and taps exposes every stage.
//   Ports: clk, reset_n (async, active low), bus (var_delay_line_if.slave)
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 1,
    parameter int MAX_DEPTH = 8,
    localparam int DW = $clog2(MAX_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    var_delay_line_if.slave bus
);

    logic          accept, clr;
    logic [DW-1:0] depth_r;
    logic [WIDTH-1:0] mem [MAX_DEPTH][CHANNELS];
    logic [CHANNELS*WIDTH-1:0] q_mux;

    var_delay_line_ctrl #(.MAX_DEPTH(MAX_DEPTH)) u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (bus.ce),
        .flush      (bus.flush),
        .depth_load (bus.depth_load),
        .depth_i    (bus.depth_i),
        .d_valid    (bus.d_valid),
        .accept     (accept),
        .clr        (clr),
        .depth_r    (depth_r),
        .q_valid    (bus.q_valid),
        .primed     (bus.primed),
        .depth_err  (bus.depth_err),
        .state      (bus.dbg_state)
    );

    for (genvar s = 0; s < MAX_DEPTH; s++) begin : g_stage
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic [WIDTH-1:0] src;
            if (s == 0) begin : g_head
                assign src = bus.d[c*WIDTH +: WIDTH];
            end else begin : g_body
                assign src = mem[s-1][c];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    mem[s][c] <= '0;
                else if (clr)
                    mem[s][c] <= '0;
                else if (accept)
                    mem[s][c] <= src;
            end

            assign bus.taps[(s*CHANNELS + c)*WIDTH +: WIDTH] = mem[s][c];
        end
    end

    // depth_r is always 1..MAX_DEPTH, so exactly one stage matches.
    always_comb begin
        q_mux = '0;
        for (int s = 0; s < MAX_DEPTH; s++) begin
            if (depth_r == DW'(s + 1)) begin
                for (int c = 0; c < CHANNELS; c++)
                    q_mux[c*WIDTH +: WIDTH] = mem[s][c];
            end
        end
    end

    assign bus.q = q_mux;

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line
//   Directed bench for var_delay_line with WIDTH=8, CHANNELS=2, MAX_DEPTH=8.
//   Channel 1 always carries channel 0's value + 0x80.
module tb_var_delay_line;
    import var_delay_line_pkg::*;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 2;
    localparam int MAX_DEPTH = 8;
    localparam int DW        = $clog2(MAX_DEPTH + 1);
    localparam int SW        = CHANNELS * WIDTH;

    logic clk;
    logic reset_n;
    int   tests;
    int   failed;

    var_delay_line_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH)) bus ();

    var_delay_line #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [SW-1:0] pair(input logic [7:0] v);
        return {v + 8'h80, v};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic ce, input logic fl, input logic ld,
                       input logic [DW-1:0] dep, input logic dv, input logic [7:0] v);
        bus.ce         = ce;
        bus.flush      = fl;
        bus.depth_load = ld;
        bus.depth_i    = dep;
        bus.d_valid    = dv;
        bus.d          = pair(v);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, v);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 8'h00);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0;
        failed = 0;
        reset_n        = 1'b0;
        bus.ce         = 1'b0;
        bus.flush      = 1'b0;
        bus.depth_load = 1'b0;
        bus.depth_i    = '0;
        bus.d_valid    = 1'b0;
        bus.d          = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_q",       bus.q,         '0);
        chk("rst_q_valid", bus.q_valid,   0);
        chk("rst_taps",    bus.taps,      '0);
        chk("rst_primed",  bus.primed,    0);
        chk("rst_err",     bus.depth_err, 0);
        chk("rst_state",   bus.dbg_state, FILL);
        reset_n = 1'b1;

        // default depth 8: first pulse after the 8th sample
        for (int k = 1; k <= 10; k++) begin
            push(8'(k));
            if (k < 8) begin
                chk("d8_qv_low", bus.q_valid, 0);
                chk("d8_primed_low", bus.primed, 0);
            end else begin
                chk("d8_qv", bus.q_valid, 1);
                chk("d8_q", bus.q, pair(8'(k - 7)));
            end
        end
        chk("d8_tap0", bus.taps[SW-1:0], pair(8'h0A));
        idle();
        chk("d8_idle_qv", bus.q_valid, 0);
        chk("d8_idle_q",  bus.q, pair(8'h03));

        // load depth 3, samples separated by idle cycles
        cyc(1'b1, 1'b0, 1'b1, DW'(3), 1'b0, 8'h00);
        chk("ld3_primed", bus.primed, 0);
        chk("ld3_qv", bus.q_valid, 0);
        push(8'h10); chk("d3_s1_qv", bus.q_valid, 0);
        idle();      chk("d3_i1_qv", bus.q_valid, 0);
        push(8'h11); chk("d3_s2_qv", bus.q_valid, 0);
        chk("d3_s2_primed", bus.primed, 0);
        idle();      chk("d3_i2_qv", bus.q_valid, 0);
        push(8'h12); chk("d3_s3_qv", bus.q_valid, 1);
        chk("d3_s3_q", bus.q, pair(8'h10));
        chk("d3_s3_primed", bus.primed, 1);
        idle();      chk("d3_i3_qv", bus.q_valid, 0);
        chk("d3_i3_q", bus.q, pair(8'h10));
        push(8'h13); chk("d3_s4_qv", bus.q_valid, 1);
        chk("d3_s4_q", bus.q, pair(8'h11));

        // reload depth 5 from RUN together with a sample
        cyc(1'b1, 1'b0, 1'b1, DW'(5), 1'b1, 8'h20);
        chk("ld5_primed", bus.primed, 0);
        chk("ld5_qv", bus.q_valid, 0);
        push(8'h21); chk("d5_a_qv", bus.q_valid, 0);
        push(8'h22); chk("d5_b_qv", bus.q_valid, 0);
        push(8'h23); chk("d5_c_qv", bus.q_valid, 0);
        push(8'h24); chk("d5_d_qv", bus.q_valid, 1);
        chk("d5_d_q", bus.q, pair(8'h20));
        chk("d5_d_primed", bus.primed, 1);

        // illegal depths flag an error but leave depth 5 and the data flow alone
        cyc(1'b1, 1'b0, 1'b1, DW'(0), 1'b1, 8'h25);
        chk("bad0_err", bus.depth_err, 1);
        chk("bad0_qv",  bus.q_valid, 1);
        chk("bad0_q",   bus.q, pair(8'h21));
        cyc(1'b1, 1'b0, 1'b1, DW'(9), 1'b1, 8'h26);
        chk("bad9_err", bus.depth_err, 1);
        chk("bad9_q",   bus.q, pair(8'h22));
        chk("bad9_primed", bus.primed, 1);
        push(8'h27);
        chk("after_bad_q", bus.q, pair(8'h23));

        // flush with a sample: everything cleared, sample dropped
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 8'h55);
        chk("fl_taps",   bus.taps, '0);
        chk("fl_qv",     bus.q_valid, 0);
        chk("fl_err",    bus.depth_err, 0);
        chk("fl_primed", bus.primed, 0);
        chk("fl_state",  bus.dbg_state, FILL);

        // ce low ignores flush, load and d_valid
        push(8'h30);
        chk("ce_pre_tap0", bus.taps[SW-1:0], pair(8'h30));
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 8'h31);
        chk("ce0_flush_tap0", bus.taps[SW-1:0], pair(8'h30));
        chk("ce0_tap1", bus.taps[2*SW-1:SW], '0);
        chk("ce0_qv", bus.q_valid, 0);
        cyc(1'b0, 1'b0, 1'b1, DW'(0), 1'b0, 8'h00);
        chk("ce0_load_err", bus.depth_err, 0);

        // depth 5 still in force: 0x30 emerges after four more samples
        push(8'h32); push(8'h33); push(8'h34);
        chk("ce_resume_qv_low", bus.q_valid, 0);
        push(8'h35);
        chk("ce_resume_qv", bus.q_valid, 1);
        chk("ce_resume_q",  bus.q, pair(8'h30));
        cyc(1'b1, 1'b0, 1'b1, DW'(12), 1'b0, 8'h00);
        chk("pre_rst_err", bus.depth_err, 1);

        // asynchronous reset between edges
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_q",      bus.q,         '0);
        chk("arst_taps",   bus.taps,      '0);
        chk("arst_primed", bus.primed,    0);
        chk("arst_err",    bus.depth_err, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // depth returns to 8 after reset
        for (int k = 1; k <= 8; k++) begin
            push(8'(8'h40 + k));
            if (k == 7) chk("rst_d8_qv_low", bus.q_valid, 0);
        end
        chk("rst_d8_qv", bus.q_valid, 1);
        chk("rst_d8_q",  bus.q, pair(8'h41));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
